// File: rtl/serial_slave_if.sv
// Serial system-bus lane bundle between one master and one slave endpoint.
interface serial_slave_if #(
  parameter int unsigned SER_WIDTH = 1
);
  logic [SER_WIDTH-1:0] swdata;
  logic                 smode;
  logic                 mvalid;
  logic [SER_WIDTH-1:0] srdata;
  logic                 svalid;
  logic                 sready;
  logic                 serr;

  modport master (
    output swdata, smode, mvalid,
    input  srdata, svalid, sready, serr
  );

  modport slave (
    input  swdata, smode, mvalid,
    output srdata, svalid, sready, serr
  );
endinterface

// File: rtl/serial_slave_ctrl.sv
// Serial-bus slave: parses LSB-first address/data frames, owns its memory and
// streams read data back after a fixed latency.
module serial_slave_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned SER_WIDTH    = 1,
  parameter int unsigned MEM_DEPTH    = 4096,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic            clk,
  input  logic            rst,
  serial_slave_if.slave   bus
);

  localparam int unsigned AB      = ADDR_WIDTH / SER_WIDTH;
  localparam int unsigned DB      = DATA_WIDTH / SER_WIDTH;
  localparam int unsigned MAX_AD  = (AB > DB) ? AB : DB;
  localparam int unsigned MAX_CNT = (MAX_AD > READ_LATENCY) ? MAX_AD : READ_LATENCY;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned MIDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WDATA, S_WRITE, S_RWAIT, S_RSEND
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  mode_q, mode_d;
  logic [SER_WIDTH-1:0]  srdata_q, srdata_d;
  logic                  svalid_q, svalid_d;
  logic                  sready_q, sready_d;
  logic                  serr_q, serr_d;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [MIDX_W-1:0]     idx_c;
  logic                  in_range_c;
  logic                  we_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  // Comparison is one bit wider so a full 2^ADDR_WIDTH depth does not wrap to zero.
  assign idx_c      = addr_q[MIDX_W-1:0];
  assign in_range_c = ({1'b0, addr_q} < DEPTH_LIM);
  assign rd_word_c  = in_range_c ? mem[idx_c] : '0;
  assign we_c       = (state_q == S_WRITE) && in_range_c && !rst;

  always_ff @(posedge clk) begin
    if (we_c) begin
      mem[idx_c] <= data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      shift_q  <= '0;
      mode_q   <= 1'b0;
      srdata_q <= '0;
      svalid_q <= 1'b0;
      sready_q <= 1'b1;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      shift_q  <= shift_d;
      mode_q   <= mode_d;
      srdata_q <= srdata_d;
      svalid_q <= svalid_d;
      sready_q <= sready_d;
      serr_q   <= serr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    shift_d  = shift_q;
    mode_d   = mode_q;
    srdata_d = srdata_q;
    svalid_d = svalid_q;
    serr_d   = serr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.mvalid) begin
          addr_d = ADDR_WIDTH'(bus.swdata);
          data_d = '0;
          mode_d = bus.smode;
          serr_d = 1'b0;
          if (AB == 1) begin
            cnt_d   = '0;
            state_d = bus.smode ? S_WDATA : S_RWAIT;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.mvalid) begin
          addr_d = addr_q | (ADDR_WIDTH'(bus.swdata) << (int'(cnt_q) * SER_WIDTH));
          if (cnt_q == CNT_W'(AB - 1)) begin
            cnt_d   = '0;
            state_d = mode_q ? S_WDATA : S_RWAIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WDATA: begin
        if (bus.mvalid) begin
          data_d = data_q | (DATA_WIDTH'(bus.swdata) << (int'(cnt_q) * SER_WIDTH));
          if (cnt_q == CNT_W'(DB - 1)) begin
            cnt_d   = '0;
            state_d = S_WRITE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_WRITE: begin
        if (!in_range_c) begin
          serr_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      S_RWAIT: begin
        // Slice 0 is presented on the same edge that enters RSEND.
        if (cnt_q == CNT_W'(READ_LATENCY - 1)) begin
          cnt_d    = '0;
          state_d  = S_RSEND;
          svalid_d = 1'b1;
          srdata_d = rd_word_c[SER_WIDTH-1:0];
          shift_d  = rd_word_c >> SER_WIDTH;
          serr_d   = !in_range_c;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RSEND: begin
        if (cnt_q == CNT_W'(DB - 1)) begin
          cnt_d    = '0;
          state_d  = S_IDLE;
          svalid_d = 1'b0;
          srdata_d = '0;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          srdata_d = shift_q[SER_WIDTH-1:0];
          shift_d  = shift_q >> SER_WIDTH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    sready_d = (state_d == S_IDLE);
  end

  assign bus.srdata = srdata_q;
  assign bus.svalid = svalid_q;
  assign bus.sready = sready_q;
  assign bus.serr   = serr_q;

endmodule
